// File: rtl/addr_dec_pkg.sv
// Shared definitions for the multi-region address decoder: FSM encoding,
// default memory map and a helper to pull one slice out of a packed map vector.
package addr_dec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Slice 0 (least significant) is region 0.
  localparam logic [127:0] DEF_REGION_BASE  = {32'h00001B00, 32'h00002000, 32'h00000000, 32'h00001730};
  localparam logic [127:0] DEF_REGION_LIMIT = {32'h00001BFF, 32'h00002FFF, 32'h000003FF, 32'h00001B2F};
  localparam logic [15:0]  DEF_WAIT_STATES  = {4'd2, 4'd3, 4'd1, 4'd0};

  localparam int VEC_W_MAX   = 1024;
  localparam int SLICE_W_MAX = 64;

  // Returns slice idx of the given width; callers truncate to their own width.
  function automatic logic [SLICE_W_MAX-1:0] slice_of(
    input logic [VEC_W_MAX-1:0] vec,
    input int unsigned          idx,
    input int unsigned          width
  );
    return SLICE_W_MAX'(vec >> (idx * width));
  endfunction

endpackage

// File: rtl/addr_region_match.sv
// Inclusive unsigned range check for one decoded region; an inverted range never hits.
module addr_region_match #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] adress,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] limit,
  output logic              hit
);

  assign hit = (adress >= base) && (adress <= limit);

endmodule

// File: rtl/addr_decoder_multi.sv
// Multi-region chip-select decoder: lowest-index priority match, registered
// one-hot select and offset, per-region wait states, then ack (plus err on a miss).
module addr_decoder_multi
  import addr_dec_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int N_REGIONS = 4,
  parameter int WAIT_W    = 4,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE  = DEF_REGION_BASE,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_LIMIT = DEF_REGION_LIMIT,
  parameter logic [N_REGIONS*WAIT_W-1:0] WAIT_STATES  = DEF_WAIT_STATES
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 req,
  input  logic [ADDR_W-1:0]    adress,
  output logic [N_REGIONS-1:0] cs,
  output logic [ADDR_W-1:0]    offset,
  output logic                 busy,
  output logic                 ack,
  output logic                 err
);

  logic [N_REGIONS-1:0] hit;
  logic [N_REGIONS-1:0] prio_hit;
  logic [ADDR_W-1:0]    base_m [N_REGIONS];
  logic [WAIT_W-1:0]    wait_m [N_REGIONS];

  genvar gi;
  generate
    for (gi = 0; gi < N_REGIONS; gi++) begin : g_region
      localparam logic [ADDR_W-1:0] BASE_I  = ADDR_W'(slice_of(VEC_W_MAX'(REGION_BASE), gi, ADDR_W));
      localparam logic [ADDR_W-1:0] LIMIT_I = ADDR_W'(slice_of(VEC_W_MAX'(REGION_LIMIT), gi, ADDR_W));
      localparam logic [WAIT_W-1:0] WAIT_I  = WAIT_W'(slice_of(VEC_W_MAX'(WAIT_STATES), gi, WAIT_W));

      addr_region_match #(.ADDR_W(ADDR_W)) u_match (
        .adress (adress),
        .base   (BASE_I),
        .limit  (LIMIT_I),
        .hit    (hit[gi])
      );

      // A region only wins when no lower-indexed region also hits.
      if (gi == 0) begin : g_first
        assign prio_hit[gi] = hit[gi];
      end else begin : g_rest
        assign prio_hit[gi] = hit[gi] & ~(|hit[gi-1:0]);
      end

      assign base_m[gi] = {ADDR_W{prio_hit[gi]}} & BASE_I;
      assign wait_m[gi] = {WAIT_W{prio_hit[gi]}} & WAIT_I;
    end
  endgenerate

  logic [ADDR_W-1:0] sel_base;
  logic [WAIT_W-1:0] sel_wait;
  logic              any_hit;

  // prio_hit is one-hot or zero, so OR-ing the masked entries acts as a mux.
  always_comb begin
    sel_base = '0;
    sel_wait = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      sel_base = sel_base | base_m[i];
      sel_wait = sel_wait | wait_m[i];
    end
  end

  assign any_hit = |hit;

  state_e               state_q, state_d;
  logic [WAIT_W-1:0]    cnt_q, cnt_d;
  logic [N_REGIONS-1:0] cs_q, cs_d;
  logic [ADDR_W-1:0]    offset_q, offset_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cs_d     = cs_q;
    offset_d = offset_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cs_d     = '0;
        offset_d = '0;
        if (req) begin
          if (any_hit) begin
            cs_d     = prio_hit;
            offset_d = adress - sel_base;
            cnt_d    = sel_wait;
            if (sel_wait != '0) begin
              state_d = WAIT;
            end else begin
              state_d = RESP;
              ack_d   = 1'b1;
            end
          end else begin
            state_d = RESP;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - WAIT_W'(1);
        if (cnt_q == WAIT_W'(1)) begin
          state_d = RESP;
          ack_d   = 1'b1;
        end
      end
      RESP: begin
        state_d  = IDLE;
        cs_d     = '0;
        offset_d = '0;
      end
      default: begin
        state_d  = IDLE;
        cs_d     = '0;
        offset_d = '0;
        cnt_d    = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cs_q     <= '0;
      offset_q <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cs_q     <= cs_d;
      offset_q <= offset_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign cs     = cs_q;
  assign offset = offset_q;
  assign busy   = busy_q;
  assign ack    = ack_q;
  assign err    = err_q;

endmodule

// File: tb/tb_addr_decoder_multi.sv
// Bench for addr_decoder_multi: directed and random accesses checked cycle by
// cycle against a range-table model of the default memory map.
module tb_addr_decoder_multi;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] adress = '0;
  logic [3:0]  cs;
  logic [31:0] offset;
  logic        busy, ack, err;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  addr_decoder_multi dut (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .req    (req),
    .adress (adress),
    .cs     (cs),
    .offset (offset),
    .busy   (busy),
    .ack    (ack),
    .err    (err)
  );

  localparam logic [31:0] M_BASE  [4] = '{32'h00001730, 32'h00000000, 32'h00002000, 32'h00001B00};
  localparam logic [31:0] M_LIMIT [4] = '{32'h00001B2F, 32'h000003FF, 32'h00002FFF, 32'h00001BFF};
  localparam int          M_WAIT  [4] = '{0, 1, 3, 2};

  function automatic int model_region(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if (a >= M_BASE[i] && a <= M_LIMIT[i]) return i;
    return -1;
  endfunction

  function automatic int model_wait(input logic [31:0] a);
    int r;
    r = model_region(a);
    return (r < 0) ? 0 : M_WAIT[r];
  endfunction

  // Expected {busy, ack, err, cs, offset} in cycle T0+k of an access to a.
  function automatic logic [38:0] model_out(input logic [31:0] a, input int k);
    int          r, w;
    logic [3:0]  c;
    logic [31:0] o;
    r = model_region(a);
    w = model_wait(a);
    if (k < 1 || k > w + 1) return '0;
    c = (r < 0) ? 4'b0000 : 4'(1 << r);
    o = (r < 0) ? 32'h0 : a - M_BASE[r];
    return {1'b1, (k == w + 1), (k == w + 1) && (r < 0), c, o};
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] edges [8];
    edges = '{M_BASE[0], M_BASE[1], M_BASE[2], M_BASE[3],
              M_LIMIT[0], M_LIMIT[1], M_LIMIT[2], M_LIMIT[3]};
    case ($urandom_range(0, 2))
      0:       return $urandom();
      1:       return 32'($urandom_range(0, 32'h3FFF));
      default: return edges[$urandom_range(0, 7)] + 32'($urandom_range(0, 2)) - 32'd1;
    endcase
  endfunction

  task automatic test_reset();
    logic [38:0] got;
    Rst_n  = 1'b0;
    req    = 1'b1;
    adress = 32'h00001730;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      got = {busy, ack, err, cs, offset};
      total++;
      if (got !== 39'h0) begin
        bad++;
        $display("FAIL reset cyc=%0d got=%h exp=0", i, got);
      end
    end
    Rst_n = 1'b1;
    req   = 1'b0;
    @(negedge Clk);
    got = {busy, ack, err, cs, offset};
    total++;
    if (got !== 39'h0) begin
      bad++;
      $display("FAIL reset_release got=%h exp=0", got);
    end
    $display("reset: done");
  endtask

  task automatic test_miss();
    logic [38:0] got, exp;
    req    = 1'b1;
    adress = 32'h0000172F;
    @(posedge Clk);
    for (int k = 1; k <= 2; k++) begin
      @(negedge Clk);
      if (k == 1) req = 1'b0;
      exp = (k == 1) ? {1'b1, 1'b1, 1'b1, 4'b0000, 32'h0} : 39'h0;
      got = {busy, ack, err, cs, offset};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL miss k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    $display("miss: adress=0000172f checked");
  endtask

  task automatic test_regions(input int n_random);
    logic [31:0] list [$];
    logic [31:0] a;
    logic [38:0] got, exp;
    int          w;
    list = '{32'h00001730, 32'h00001B2F, 32'h00001B30, 32'h00001BFF, 32'h00001C00,
             32'h00000000, 32'h000003FF, 32'h00000400, 32'h00002FFF, 32'h00003000,
             32'hFFFFFFFF};
    for (int i = 0; i < n_random; i++) list.push_back(rand_addr());
    foreach (list[n]) begin
      a      = list[n];
      w      = model_wait(a);
      req    = 1'b1;
      adress = a;
      @(posedge Clk);
      for (int k = 1; k <= w + 2; k++) begin
        @(negedge Clk);
        if (k == 1) req = 1'b0;
        exp = model_out(a, k);
        got = {busy, ack, err, cs, offset};
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL region a=%h k=%0d got=%h exp=%h", a, k, got, exp);
        end
      end
      $display("access: adress=%h region=%0d wait=%0d", a, model_region(a), w);
    end
  endtask

  task automatic test_ignored_req();
    logic [38:0] got, exp;
    req    = 1'b1;
    adress = 32'h00002000;
    @(posedge Clk);
    for (int k = 1; k <= 7; k++) begin
      @(negedge Clk);
      exp = (k <= 4) ? {1'b1, (k == 4), 1'b0, 4'b0100, 32'h0} : 39'h0;
      got = {busy, ack, err, cs, offset};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL ignored_req k=%0d got=%h exp=%h", k, got, exp);
      end
      if (k == 1) req = 1'b0;
      if (k == 2) begin
        req    = 1'b1;
        adress = 32'h00000000;
      end
      if (k == 5) req = 1'b0;
    end
    $display("ignored_req: second request during WAIT/RESP checked");
  endtask

  task automatic test_reset_mid_wait();
    logic [38:0] got, exp;
    req    = 1'b1;
    adress = 32'h00002500;
    @(posedge Clk);
    for (int k = 1; k <= 2; k++) begin
      @(negedge Clk);
      if (k == 1) req = 1'b0;
      exp = {1'b1, 1'b0, 1'b0, 4'b0100, 32'h500};
      got = {busy, ack, err, cs, offset};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL midwait_pre k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    #2 Rst_n = 1'b0;
    #1;
    got = {busy, ack, err, cs, offset};
    total++;
    if (got !== 39'h0) begin
      bad++;
      $display("FAIL midwait_async got=%h exp=0", got);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      if (k == 2) Rst_n = 1'b1;
      got = {busy, ack, err, cs, offset};
      total++;
      if (got !== 39'h0) begin
        bad++;
        $display("FAIL midwait_abort k=%0d got=%h exp=0", k, got);
      end
    end
    req    = 1'b1;
    adress = 32'h00000010;
    @(posedge Clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge Clk);
      if (k == 1) req = 1'b0;
      exp = (k <= 2) ? {1'b1, (k == 2), 1'b0, 4'b0010, 32'h10} : 39'h0;
      got = {busy, ack, err, cs, offset};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL midwait_after k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    $display("reset_mid_wait: abort and recovery checked");
  endtask

  task automatic test_back_to_back();
    logic [31:0] list [4];
    logic [1:0]  got, exp;
    int          w;
    list = '{32'h00001730, 32'h00000010, 32'h00001B30, 32'h00005000};
    foreach (list[n]) begin
      w      = model_wait(list[n]);
      req    = 1'b1;
      adress = list[n];
      @(posedge Clk);
      for (int k = 1; k <= 3 * (w + 2); k++) begin
        @(negedge Clk);
        exp = {((k % (w + 2)) != 0), (k >= w + 1) && (((k - (w + 1)) % (w + 2)) == 0)};
        got = {busy, ack};
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL b2b a=%h k=%0d got(busy,ack)=%b exp=%b", list[n], k, got, exp);
        end
      end
      req = 1'b0;
      @(negedge Clk);
      $display("back_to_back: adress=%h spacing=%0d", list[n], w + 2);
    end
  endtask

  initial begin
    test_reset();
    test_miss();
    test_regions(40);
    test_ignored_req();
    test_reset_mid_wait();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/addr_decoder_multi.md
Name: addr_decoder_multi

Overview:
- Parametrised successor to the single-range chip-select decoder for the MIPS memory map.
- Decodes a request address against N_REGIONS programmable inclusive ranges using fixed lowest-index priority.
- Produces a registered one-hot chip select and a region-local offset.
- Inserts per-region wait states, then closes each access with a one-cycle ack, or ack plus err when the address is unmapped.
- Sits between the CPU data-memory port and the memory/peripheral slaves.

Parameters:
- ADDR_W, 32: address and offset width.
- N_REGIONS, 4: number of decoded regions and the width of cs.
- WAIT_W, 4: width of each wait-state field.
- REGION_BASE, {32'h00001B00, 32'h00002000, 32'h00000000, 32'h00001730}: packed N_REGIONS*ADDR_W vector. Region i occupies slice i, and region 0 is the least-significant slice.
- REGION_LIMIT, {32'h00001BFF, 32'h00002FFF, 32'h000003FF, 32'h00001B2F}: packed N_REGIONS*ADDR_W vector of inclusive upper bounds.
- WAIT_STATES, {4'd2, 4'd3, 4'd1, 4'd0}: packed N_REGIONS*WAIT_W vector of wait states per region.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- req  in  1  access request; sampled only in IDLE.
- adress  in  ADDR_W  request address; sampled together with req.
- cs  out  N_REGIONS  registered one-hot chip select.
- offset  out  ADDR_W  registered value of adress minus the matched REGION_BASE.
- busy  out  1  high whenever state is not IDLE.
- ack  out  1  one-cycle completion pulse.
- err  out  1  one-cycle unmapped-address pulse; always coincident with ack.

Behaviour:
- Reset:
  - Rst_n low clears, asynchronously: cs=0, offset=0, busy=0, ack=0, err=0, wait counter=0, state=IDLE.
  - A reset asserted mid-access aborts it; no ack or err is issued for the aborted access.
- Match rule:
  - Region i hits when REGION_BASE[i] <= adress <= REGION_LIMIT[i], using an unsigned compare with both bounds inclusive.
  - A region with BASE > LIMIT never hits.
  - When ranges overlap, the lowest hit index wins. With the defaults, 0x1B00..0x1B2F resolves to region 0.
- States are IDLE, WAIT and RESP.
- IDLE:
  - With req=1 at the rising edge, latch the outcome.
  - Hit on region i: cs=one-hot(i), offset=adress-REGION_BASE[i] (ADDR_W bits), counter=WAIT_STATES[i]. Next state is WAIT if WAIT_STATES[i]>0, else RESP.
  - Miss: cs=0, offset=0, next state RESP, with err flagged.
  - With req=0, remain in IDLE with all outputs 0.
- WAIT:
  - The counter decrements by 1 each cycle.
  - When the counter equals 1 at an edge, the next state is RESP.
  - cs and offset hold their values.
- RESP:
  - Lasts exactly one cycle with ack=1 and err=1 only if the access missed.
  - At the next edge, cs, offset, ack and err clear and the state returns to IDLE.
- Latency:
  - Counting the sampling edge as T0, RESP and ack are visible in cycle T0+W+1, where W is the matched region's wait-state count.
  - A miss has W=0.
- busy is high from T0+1 through the RESP cycle inclusive.
- Requests outside IDLE:
  - req and adress are ignored in WAIT and RESP.
  - Requests are not queued; the requester must hold or re-issue req.
  - The earliest next acceptance is the edge that ends RESP plus one cycle. Minimum spacing is W+2 cycles.
- Outputs are driven only from registers. No combinational path exists from adress to cs.

Decomposition:
- Package addr_dec_pkg holds:
  - the state encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2;
  - the default REGION_BASE, REGION_LIMIT and WAIT_STATES constants;
  - a function that extracts slice i from a packed parameter vector.
- Sub-module addr_region_match: purely combinational; inputs adress, base and limit; output hit. It is generated N_REGIONS times.
- The top level holds the priority encoder, offset subtractor, FSM and wait counter.

Test Plan:
- Reset: hold Rst_n=0 for 3 cycles with req=1 and adress=0x1730 → cs=0, offset=0, busy=0, ack=0, err=0 throughout.
- Miss below range: req pulse with adress=0x172F → next cycle ack=1, err=1, cs=0, busy=1; one cycle later everything is back to 0.
- Range start, zero wait: adress=0x1730 → at T0+1 cs=4'b0001, offset=0, ack=1, err=0.
- Overlap and boundaries:
  - adress=0x1B2F → cs=4'b0001, offset=0x3FF, ack at T0+1.
  - adress=0x1B30 → cs=4'b1000, offset=0x30, busy for 3 cycles, ack at T0+3.
- Wait states and ignored request: adress=0x2000 (region 2, W=3), then req with adress=0x0000 at T0+2 → cs=4'b0100 held; ack at T0+4 only; the second request produces no access.
- Reset mid-wait: start adress=0x2500, drop Rst_n during WAIT → outputs 0 immediately and no ack; after release, adress=0x0010 → cs=4'b0010, offset=0x10, ack at T0+2.
